// File: rtl/reg9_serializer.sv
// Serializes a captured 9-bit word as start, 9 data bits LSB first,
// optional even parity and stop; busy/done report frame progress.
//
// state    | meaning
// ---------+-----------------------------------------------------
// S_IDLE   | line high, waiting for start
// S_START  | start bit (line low) for CLKS_PER_BIT cycles
// S_DATA   | shift register bit 0 on the line, 9 bits
// S_PARITY | XOR of the captured word (PARITY_EN only)
// S_STOP   | stop bit (line high); exit pulses done
module reg9_serializer #(
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [8:0] writeData,
    output logic       serialOut,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [7:0] DIV_MAX = 8'(CLKS_PER_BIT - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_div;
    logic [7:0] w_div_next;
    logic [3:0] r_bit_cnt;
    logic [3:0] w_bit_cnt_next;
    logic [8:0] r_shift;
    logic [8:0] w_shift_next;
    logic       r_parity;
    logic       w_parity_next;
    logic       r_serial_out;
    logic       r_busy;
    logic       r_done;
    logic       w_serial_next;
    logic       w_busy_next;
    logic       w_done_next;
    logic       w_div_done;

    assign w_div_done = (r_div == DIV_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_div        <= 8'd0;
            r_bit_cnt    <= 4'd0;
            r_shift      <= 9'd0;
            r_parity     <= 1'b0;
            r_serial_out <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_div        <= w_div_next;
            r_bit_cnt    <= w_bit_cnt_next;
            r_shift      <= w_shift_next;
            r_parity     <= w_parity_next;
            r_serial_out <= w_serial_next;
            r_busy       <= w_busy_next;
            r_done       <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_next = S_START;
            S_START:  if (w_div_done) w_state_next = S_DATA;
            S_DATA: begin
                if (w_div_done && (r_bit_cnt == 4'd8))
                    w_state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: if (w_div_done) w_state_next = S_STOP;
            S_STOP:   if (w_div_done) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Datapath: divider restarts on every state entry and every data-bit advance.
    always_comb begin
        w_shift_next   = r_shift;
        w_parity_next  = r_parity;
        w_bit_cnt_next = r_bit_cnt;
        if ((r_state == S_IDLE) || (w_state_next != r_state) || w_div_done)
            w_div_next = 8'd0;
        else
            w_div_next = r_div + 8'd1;

        if ((r_state == S_IDLE) && start) begin
            w_shift_next   = writeData;
            w_parity_next  = ^writeData;
            w_bit_cnt_next = 4'd0;
        end else if ((r_state == S_DATA) && w_div_done) begin
            w_shift_next = {1'b0, r_shift[8:1]};
            if (r_bit_cnt != 4'd8)
                w_bit_cnt_next = r_bit_cnt + 4'd1;
        end
    end

    always_comb begin
        w_serial_next = 1'b1;
        case (w_state_next)
            S_IDLE:   w_serial_next = 1'b1;
            S_START:  w_serial_next = 1'b0;
            S_DATA:   w_serial_next = w_shift_next[0];
            S_PARITY: w_serial_next = w_parity_next;
            S_STOP:   w_serial_next = 1'b1;
            default:  w_serial_next = 1'b1;
        endcase
        w_busy_next = (w_state_next != S_IDLE);
        w_done_next = (r_state == S_STOP) && (w_state_next == S_IDLE);
    end

    assign serialOut = r_serial_out;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
